// File: rtl/miriscv_data_bus.sv
// Single-master data bus: routes one core transfer at a time to N_SLV slaves by address field.
// Zero-wait read/write costs 3 cycles grant-to-rvalid; decode errors and slave timeouts return err.
module miriscv_data_bus #(
  parameter int N_SLV   = 4,
  parameter int SEL_LSB = 28,
  parameter int TIMEOUT = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                core_req_i,
  input  logic                core_we_i,
  input  logic [3:0]          core_be_i,
  input  logic [31:0]         core_addr_i,
  input  logic [31:0]         core_wdata_i,
  output logic                core_gnt_o,
  output logic                core_rvalid_o,
  output logic [31:0]         core_rdata_o,
  output logic                core_err_o,
  output logic [N_SLV-1:0]    slv_req_o,
  output logic                slv_we_o,
  output logic [3:0]          slv_be_o,
  output logic [31:0]         slv_addr_o,
  output logic [31:0]         slv_wdata_o,
  input  logic [N_SLV-1:0]    slv_gnt_i,
  input  logic [N_SLV-1:0]    slv_rvalid_i,
  input  logic [32*N_SLV-1:0] slv_rdata_i,
  output logic [7:0]          err_cnt_o
);

  typedef enum logic [2:0] {IDLE, REQ, RESP, DONE, ERR} state_t;

  state_t             state_q, state_d;
  logic               we_q, we_d;
  logic [3:0]         be_q, be_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         sel_q, sel_d;
  logic [31:0]        data_q, data_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [7:0]         err_cnt_q, err_cnt_d;
  logic [N_SLV-1:0]   slv_req_q, slv_req_d;
  logic               rvalid_q, rvalid_d;
  logic               err_q, err_d;
  logic [31:0]        rdata_q, rdata_d;

  logic               sel_gnt, sel_rvalid, sel_ok, timeout_hit;
  logic [31:0]        sel_rdata;

  assign core_gnt_o  = core_req_i & (state_q == IDLE) & rst_n_i;
  assign sel_ok      = ({28'd0, sel_q} < 32'(N_SLV));
  assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));

  // Only the latched slave's handshake and data are ever looked at.
  always_comb begin
    sel_gnt    = 1'b0;
    sel_rvalid = 1'b0;
    sel_rdata  = '0;
    for (int k = 0; k < N_SLV; k++) begin
      if (sel_q == 4'(k)) begin
        sel_gnt    = slv_gnt_i[k];
        sel_rvalid = slv_rvalid_i[k];
        sel_rdata  = slv_rdata_i[32*k +: 32];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    be_d      = be_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    sel_d     = sel_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (core_gnt_o) begin
          we_d    = core_we_i;
          be_d    = core_be_i;
          addr_d  = core_addr_i;
          wdata_d = core_wdata_i;
          sel_d   = core_addr_i[SEL_LSB+3:SEL_LSB];
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        cnt_d = cnt_q + 8'd1;
        // Decode is resolved on the latched select in the first REQ cycle; no slave sees it.
        if (!sel_ok)          state_d = ERR;
        else if (sel_gnt)     state_d = RESP;
        else if (timeout_hit) state_d = ERR;
      end
      RESP: begin
        cnt_d = cnt_q + 8'd1;
        if (sel_rvalid) begin
          data_d  = sel_rdata;
          state_d = DONE;
        end else if (timeout_hit) begin
          state_d = ERR;
        end
      end
      DONE: state_d = IDLE;
      ERR: begin
        state_d = IDLE;
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    slv_req_d = '0;
    for (int k = 0; k < N_SLV; k++) begin
      slv_req_d[k] = (state_d == REQ) && (sel_d == 4'(k));
    end
    rvalid_d = (state_d == DONE) || (state_d == ERR);
    err_d    = (state_d == ERR);
    rdata_d  = (state_d == DONE) ? data_d : 32'd0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      be_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      sel_q     <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      err_cnt_q <= '0;
      slv_req_q <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      be_q      <= be_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      sel_q     <= sel_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      err_cnt_q <= err_cnt_d;
      slv_req_q <= slv_req_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign core_rvalid_o = rvalid_q;
  assign core_err_o    = err_q;
  assign core_rdata_o  = rdata_q;
  assign slv_req_o     = slv_req_q;
  assign slv_we_o      = we_q;
  assign slv_be_o      = be_q;
  assign slv_addr_o    = addr_q;
  assign slv_wdata_o   = wdata_q;
  assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_miriscv_data_bus.sv
// Scenario bench for miriscv_data_bus: expected responses are queued at grant and popped at rvalid.
module tb_miriscv_data_bus;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         core_req, core_we;
  logic [3:0]   core_be;
  logic [31:0]  core_addr, core_wdata;
  logic         core_gnt, core_rvalid, core_err;
  logic [31:0]  core_rdata;
  logic [3:0]   slv_req;
  logic         slv_we;
  logic [3:0]   slv_be;
  logic [31:0]  slv_addr, slv_wdata;
  logic [3:0]   slv_gnt, slv_rvalid;
  logic [127:0] slv_rdata;
  logic [7:0]   err_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic err; logic [31:0] data; } exp_t;
  exp_t exp_q[$];
  exp_t e;

  always #5 clk = ~clk;

  miriscv_data_bus #(.N_SLV(4), .SEL_LSB(28), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .core_req_i(core_req), .core_we_i(core_we), .core_be_i(core_be),
    .core_addr_i(core_addr), .core_wdata_i(core_wdata),
    .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid),
    .core_rdata_o(core_rdata), .core_err_o(core_err),
    .slv_req_o(slv_req), .slv_we_o(slv_we), .slv_be_o(slv_be),
    .slv_addr_o(slv_addr), .slv_wdata_o(slv_wdata),
    .slv_gnt_i(slv_gnt), .slv_rvalid_i(slv_rvalid), .slv_rdata_i(slv_rdata),
    .err_cnt_o(err_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Drives a request just after a rising edge and samples the grant at the following falling edge.
  task automatic do_grant(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic got);
    core_req = 1'b1; core_we = we; core_be = be; core_addr = addr; core_wdata = wdata;
    smp();
    got = core_gnt;
  endtask

  // Counts cycles from the grant sample until rvalid; n = -1 if the budget runs out.
  task automatic wait_rsp(input int max_cyc, output int n);
    n = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      tick();
      smp();
      if (core_rvalid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; core_req = 1'b1; core_we = 1'b1; core_be = 4'hF;
    core_addr = 32'h1000_0000; core_wdata = 32'hFFFF_FFFF;
    slv_gnt = 4'hF; slv_rvalid = 4'hF; slv_rdata = {4{32'hA5A5_A5A5}};
    repeat (3) smp();
    checks++;
    if ({core_gnt, core_rvalid, core_err, core_rdata, slv_req, slv_we, slv_be, slv_addr, slv_wdata, err_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b rvalid=%b err=%b rdata=%h req=%b be=%h addr=%h wdata=%h cnt=%0d, all required 0",
               core_gnt, core_rvalid, core_err, core_rdata, slv_req, slv_be, slv_addr, slv_wdata, err_cnt);
    end
    core_req = 1'b0; slv_gnt = '0; slv_rvalid = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_read();
    logic got;
    int n;
    tick();
    do_grant(1'b0, 4'hF, 32'h1000_0004, 32'h0, got);
    checks++;
    if (got !== 1'b1) begin errors++; $display("FAIL read_first_gnt: gnt=%b required 1", got); end
    exp_q.push_back('{1'b0, 32'hDEAD_BEEF});
    tick();
    core_req = 1'b0; slv_gnt = 4'b0010;
    smp();
    checks++;
    if ({slv_req, slv_addr, core_rvalid} !== {4'b0010, 32'h1000_0004, 1'b0}) begin
      errors++; $display("FAIL read_req: req=%b addr=%h rvalid=%b required 0010 10000004 0", slv_req, slv_addr, core_rvalid);
    end
    tick();
    // Slave 0 also raises rvalid with other data; only slave 1 may be taken.
    slv_gnt = '0; slv_rvalid = 4'b0011;
    slv_rdata = {32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0BAD_0BAD};
    smp();
    checks++;
    if ({slv_req, core_rvalid} !== 5'b0) begin
      errors++; $display("FAIL read_resp: req=%b rvalid=%b required 0000 0", slv_req, core_rvalid);
    end
    tick();
    slv_rvalid = '0; slv_rdata = '0;
    smp();
    n = core_rvalid ? 3 : -1;
    checks++;
    if (n !== 3) begin errors++; $display("FAIL read_latency: rvalid=%b at cycle 3, required 1", core_rvalid); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL read_scoreboard: queue empty"); end
    else begin
      e = exp_q.pop_front();
      if ({core_err, core_rdata} !== {e.err, e.data}) begin
        errors++; $display("FAIL read_data: err=%b rdata=%h required err=%b rdata=%h", core_err, core_rdata, e.err, e.data);
      end
    end
    tick();
    smp();
    checks++;
    if (core_rvalid !== 1'b0) begin errors++; $display("FAIL read_pulse: rvalid=%b required 0", core_rvalid); end
  endtask

  task automatic test_write();
    logic got;
    int n;
    tick();
    do_grant(1'b1, 4'b0011, 32'h0000_0010, 32'h1234_5678, got);
    checks++;
    if (got !== 1'b1) begin errors++; $display("FAIL write_gnt: gnt=%b required 1", got); end
    exp_q.push_back('{1'b0, 32'h0000_00AA});
    tick();
    core_req = 1'b0; core_be = 4'hF; core_wdata = 32'h0; core_we = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) slv_gnt = 4'b0001;
      smp();
      checks++;
      if ({slv_req, slv_we, slv_be, slv_wdata} !== {4'b0001, 1'b1, 4'b0011, 32'h1234_5678}) begin
        errors++; $display("FAIL write_hold_%0d: req=%b we=%b be=%b wdata=%h required 0001 1 0011 12345678",
                           c, slv_req, slv_we, slv_be, slv_wdata);
      end
      tick();
    end
    slv_gnt = '0; slv_rvalid = 4'b0001; slv_rdata = {96'h0, 32'h0000_00AA};
    smp();
    tick();
    slv_rvalid = '0;
    smp();
    checks++;
    if (core_rvalid !== 1'b1) begin errors++; $display("FAIL write_rvalid: rvalid=%b required 1", core_rvalid); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL write_scoreboard: queue empty"); end
    else begin
      e = exp_q.pop_front();
      if ({core_err, core_rdata} !== {e.err, e.data}) begin
        errors++; $display("FAIL write_rsp: err=%b rdata=%h required err=%b rdata=%h", core_err, core_rdata, e.err, e.data);
      end
    end
    slv_rdata = '0;
  endtask

  // Request held high across the error: no grant until the cycle after ERR.
  task automatic test_decode_err();
    logic got;
    tick();
    do_grant(1'b0, 4'hF, 32'h5000_0000, 32'h0, got);
    checks++;
    if (got !== 1'b1) begin errors++; $display("FAIL dec_gnt: gnt=%b required 1", got); end
    exp_q.push_back('{1'b1, 32'h0});
    tick(); smp();
    checks++;
    if ({core_gnt, slv_req, core_rvalid} !== 6'b0) begin
      errors++; $display("FAIL dec_cycle1: gnt=%b req=%b rvalid=%b required 0", core_gnt, slv_req, core_rvalid);
    end
    tick(); smp();
    checks++;
    if ({core_rvalid, core_gnt, slv_req} !== {1'b1, 1'b0, 4'b0}) begin
      errors++; $display("FAIL dec_cycle2: rvalid=%b gnt=%b req=%b required 1 0 0000", core_rvalid, core_gnt, slv_req);
    end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL dec_scoreboard: queue empty"); end
    else begin
      e = exp_q.pop_front();
      if ({core_err, core_rdata} !== {e.err, e.data}) begin
        errors++; $display("FAIL dec_rsp: err=%b rdata=%h required err=%b rdata=%h", core_err, core_rdata, e.err, e.data);
      end
    end
    tick(); smp();
    checks++;
    if ({core_gnt, err_cnt} !== {1'b1, 8'd1}) begin
      errors++; $display("FAIL dec_regrant: gnt=%b err_cnt=%0d required 1 1", core_gnt, err_cnt);
    end
    exp_q.push_back('{1'b1, 32'h0});
    tick();
    core_req = 1'b0;
    smp(); tick(); smp();
    checks++;
    if (exp_q.size() == 0 || core_rvalid !== 1'b1) begin
      errors++; $display("FAIL dec_second: rvalid=%b queued=%0d required 1 1", core_rvalid, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if ({core_err, core_rdata} !== {e.err, e.data}) begin
        errors++; $display("FAIL dec_second_rsp: err=%b rdata=%h required err=%b rdata=%h", core_err, core_rdata, e.err, e.data);
      end
    end
    tick(); smp();
    checks++;
    if (err_cnt !== 8'd2) begin errors++; $display("FAIL dec_err_cnt: err_cnt=%0d required 2", err_cnt); end
  endtask

  task automatic test_timeout();
    logic got;
    int n;
    tick();
    do_grant(1'b0, 4'hF, 32'h2000_0000, 32'h0, got);
    exp_q.push_back('{1'b1, 32'h0});
    tick();
    core_req = 1'b0;
    smp();
    checks++;
    if (got !== 1'b1 || slv_req !== 4'b0100) begin
      errors++; $display("FAIL to_req: gnt=%b req=%b required 1 0100", got, slv_req);
    end
    wait_rsp(39, n);
    n = (n < 0) ? -1 : n + 1;
    checks++;
    if (n !== 17) begin errors++; $display("FAIL to_latency: rvalid at cycle %0d required 17", n); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL to_scoreboard: queue empty"); end
    else begin
      e = exp_q.pop_front();
      if ({core_err, core_rdata} !== {e.err, e.data}) begin
        errors++; $display("FAIL to_rsp: err=%b rdata=%h required err=%b rdata=%h", core_err, core_rdata, e.err, e.data);
      end
    end
    tick();
    slv_rvalid = 4'b0100; slv_rdata = {32'h0, 32'h7777_7777, 64'h0};
    smp();
    checks++;
    if (err_cnt !== 8'd3) begin errors++; $display("FAIL to_err_cnt: err_cnt=%0d required 3", err_cnt); end
    tick();
    slv_rvalid = '0;
    smp();
    checks++;
    if ({core_rvalid, core_rdata} !== 33'b0) begin
      errors++; $display("FAIL to_late_rvalid: rvalid=%b rdata=%h required 0", core_rvalid, core_rdata);
    end
    slv_rdata = '0;
  endtask

  task automatic test_reset_mid();
    logic got;
    int n;
    tick();
    do_grant(1'b1, 4'hF, 32'h3000_0008, 32'hCCCC_CCCC, got);
    tick();
    core_req = 1'b0; slv_gnt = 4'b1000;
    tick();
    slv_gnt = '0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({core_rvalid, core_err, core_rdata, slv_req, slv_we, slv_be, slv_addr, slv_wdata, err_cnt} !== '0) begin
      errors++; $display("FAIL mid_reset: rvalid=%b req=%b addr=%h wdata=%h err_cnt=%0d required 0",
                         core_rvalid, slv_req, slv_addr, slv_wdata, err_cnt);
    end
    smp();
    rst_n = 1'b1;
    tick();
    do_grant(1'b0, 4'hF, 32'h0000_0000, 32'h0, got);
    checks++;
    if (got !== 1'b1) begin errors++; $display("FAIL mid_regrant: gnt=%b required 1", got); end
    exp_q.push_back('{1'b0, 32'h55AA_55AA});
    tick();
    // gnt and rvalid together in REQ: the rvalid must not complete the transfer.
    core_req = 1'b0; slv_gnt = 4'b0001; slv_rvalid = 4'b0001; slv_rdata = {96'h0, 32'h1111_1111};
    smp(); tick();
    slv_gnt = '0; slv_rvalid = '0;
    smp(); tick();
    slv_rvalid = 4'b0001; slv_rdata = {96'h0, 32'h55AA_55AA};
    smp(); tick();
    slv_rvalid = '0; slv_rdata = '0;
    smp();
    n = core_rvalid ? 4 : -1;
    if (n < 0) wait_rsp(4, n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL mid_gnt_rvalid: rvalid at cycle %0d required 4", n); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL mid_scoreboard: queue empty"); end
    else begin
      e = exp_q.pop_front();
      if ({core_err, core_rdata} !== {e.err, e.data}) begin
        errors++; $display("FAIL mid_rsp: err=%b rdata=%h required err=%b rdata=%h", core_err, core_rdata, e.err, e.data);
      end
    end
  endtask

  task automatic test_saturate();
    logic got;
    int n;
    int bad = 0;
    for (int i = 0; i < 257; i++) begin
      tick();
      do_grant(1'b0, 4'hF, 32'hF000_0000, 32'h0, got);
      exp_q.push_back('{1'b1, 32'h0});
      tick();
      core_req = 1'b0;
      smp();
      wait_rsp(4, n);
      if (exp_q.size() != 0) e = exp_q.pop_front();
      if (!got || n < 0 || {core_err, core_rdata} !== {e.err, e.data}) bad++;
      tick(); smp();
      if (i == 255) begin
        checks++;
        if (err_cnt !== 8'd255) begin errors++; $display("FAIL sat_reach: err_cnt=%0d required 255", err_cnt); end
      end
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL sat_responses: %0d bad error responses, required 0", bad); end
    checks++;
    if (err_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold: err_cnt=%0d required 255", err_cnt); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_decode_err();
    test_timeout();
    test_reset_mid();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
